// File: rtl/ps2_pkg.sv
// Shared PS/2 receive definitions: FSM encoding and scan-code constants
// also consumed by the tone generator.
package ps2_pkg;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  localparam logic [7:0]  PS2_BREAK     = 8'hF0;
  localparam logic [7:0]  PS2_EXT       = 8'hE0;
  localparam int unsigned PS2_DATA_BITS = 8;

endpackage

// File: rtl/ps2_clk_filter.sv
// Synchronises the raw PS/2 clock, rejects glitches shorter than FILTER_LEN
// samples and emits a one-cycle pulse on each filtered falling edge.
module ps2_clk_filter #(
  parameter int unsigned FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic ps2_clk,
  output logic fall
);

  logic [1:0] sync;
  logic       filt;
  logic [7:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync <= '1;
      filt <= 1'b1;
      cnt  <= '0;
      fall <= 1'b0;
    end else begin
      sync <= {sync[0], ps2_clk};
      fall <= 1'b0;
      if (sync[1] != filt) begin
        if (cnt == 8'(FILTER_LEN - 1)) begin
          filt <= sync[1];
          cnt  <= '0;
          fall <= filt;
        end else begin
          cnt <= cnt + 8'd1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/ps2_keycode_rx.sv
// PS/2 keyboard frame receiver: validates start/parity/stop and shifts each
// accepted byte into a two-byte keycode history for the tone generator.
module ps2_keycode_rx
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [15:0] keycode,
  output logic        key_valid,
  output logic        frame_err,
  output logic        rx_busy
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  state_t                     state, state_next;
  logic [1:0]                 data_sync;
  logic                       data;
  logic                       fall;
  logic [2:0]                 bit_cnt;
  logic [PS2_DATA_BITS-1:0]   shreg;
  logic                       par_bit;
  logic [TW-1:0]              tcnt;
  logic                       timeout, start, shift_en, par_en, accept, reject;

  assign data = data_sync[1];

  ps2_clk_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
    .clk     (clk),
    .rst     (rst),
    .ps2_clk (ps2_clk),
    .fall    (fall)
  );

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (timeout) begin
      state_next = IDLE;
    end else if (fall) begin
      unique case (state)
        IDLE:   if (!data) state_next = DATA;
        DATA:   if (bit_cnt == 3'(PS2_DATA_BITS - 1)) state_next = PARITY;
        PARITY: state_next = STOP;
        STOP:   state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // tcnt counts cycles since the last fall (fall cycle included), so the abort
  // edge is the one on which it would reach TIMEOUT_CYCLES; timeout beats fall.
  always_comb begin
    rx_busy  = (state != IDLE);
    timeout  = rx_busy && (tcnt == TW'(TIMEOUT_CYCLES - 1));
    start    = fall && (state == IDLE) && !data;
    shift_en = fall && !timeout && (state == DATA);
    par_en   = fall && !timeout && (state == PARITY);
    accept   = fall && !timeout && (state == STOP) && data && (^{shreg, par_bit});
    reject   = timeout || (fall && (state == STOP) && !accept);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      data_sync <= '1;
      keycode   <= '0;
      key_valid <= 1'b0;
      frame_err <= 1'b0;
      bit_cnt   <= '0;
      shreg     <= '0;
      par_bit   <= 1'b0;
      tcnt      <= '0;
    end else begin
      data_sync <= {data_sync[0], ps2_data};
      key_valid <= accept;
      frame_err <= reject;
      if (accept)   keycode <= {keycode[7:0], shreg};
      if (start)         bit_cnt <= '0;
      else if (shift_en) bit_cnt <= bit_cnt + 3'd1;
      if (shift_en) shreg <= {data, shreg[PS2_DATA_BITS-1:1]};
      if (par_en)   par_bit <= data;
      if (state_next == IDLE) tcnt <= '0;
      else if (fall)          tcnt <= TW'(1);
      else                    tcnt <= tcnt + TW'(1);
    end
  end

endmodule

// File: tb/tb_ps2_keycode_rx.sv
// Directed bench for ps2_keycode_rx: good, bad, timed-out, glitched and
// reset-interrupted PS/2 frames with hand-computed expected keycodes.
module tb_ps2_keycode_rx;

  localparam int unsigned FL   = 4;
  localparam int unsigned TO   = 2000;
  localparam int unsigned HALF = 200;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ps2_clk = 1'b1;
  logic        ps2_data = 1'b1;
  logic [15:0] keycode;
  logic        key_valid, frame_err, rx_busy;

  int compared = 0, mismatched = 0;
  int kv_cnt = 0, fe_cnt = 0, both_cnt = 0;
  int cyc = 0, fe_cyc = 0, pin_fall_cyc = 0;

  ps2_keycode_rx #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
    .clk       (clk),
    .rst       (rst),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .keycode   (keycode),
    .key_valid (key_valid),
    .frame_err (frame_err),
    .rx_busy   (rx_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (key_valid) kv_cnt++;
    if (frame_err) begin
      fe_cnt++;
      fe_cyc = cyc;
    end
    if (key_valid && frame_err) both_cnt++;
  end

  task automatic ps2_bit(input logic b);
    repeat (HALF / 2) @(negedge clk);
    ps2_data = b;
    repeat (HALF / 2) @(negedge clk);
    ps2_clk = 1'b0;
    pin_fall_cyc = cyc;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic idle_gap();
    repeat (HALF / 2) @(negedge clk);
    ps2_data = 1'b1;
    repeat (300) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic good_par, input logic stop);
    logic [7:0] v;
    v = b;
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(v[i]);
    ps2_bit(good_par ? ~(^v) : ^v);
    ps2_bit(stop);
    idle_gap();
  endtask

  task automatic do_reset();
    @(negedge clk) rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (4) @(negedge clk);
    compared++; if (keycode !== 16'h0000) begin mismatched++; $display("FAIL reset_keycode: got %h want 0000", keycode); end
    compared++; if (key_valid !== 1'b0) begin mismatched++; $display("FAIL reset_key_valid: got %b want 0", key_valid); end
    compared++; if (frame_err !== 1'b0) begin mismatched++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
    compared++; if (rx_busy !== 1'b0) begin mismatched++; $display("FAIL reset_rx_busy: got %b want 0", rx_busy); end
    rst = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_single();
    int k0, f0;
    k0 = kv_cnt; f0 = fe_cnt;
    send_frame(8'h1C, 1'b1, 1'b1);
    compared++; if (kv_cnt - k0 != 1) begin mismatched++; $display("FAIL single_kv_pulses: got %0d want 1", kv_cnt - k0); end
    compared++; if (keycode !== 16'h001C) begin mismatched++; $display("FAIL single_keycode: got %h want 001c", keycode); end
    compared++; if (fe_cnt - f0 != 0) begin mismatched++; $display("FAIL single_frame_err: got %0d want 0", fe_cnt - f0); end
  endtask

  task automatic test_sequence();
    int k0;
    do_reset();
    k0 = kv_cnt;
    send_frame(8'h1C, 1'b1, 1'b1);
    compared++; if (keycode !== 16'h001C) begin mismatched++; $display("FAIL seq_keycode1: got %h want 001c", keycode); end
    send_frame(8'hF0, 1'b1, 1'b1);
    compared++; if (keycode !== 16'h1CF0) begin mismatched++; $display("FAIL seq_keycode2: got %h want 1cf0", keycode); end
    send_frame(8'h1C, 1'b1, 1'b1);
    compared++; if (keycode !== 16'hF01C) begin mismatched++; $display("FAIL seq_keycode3: got %h want f01c", keycode); end
    compared++; if (kv_cnt - k0 != 3) begin mismatched++; $display("FAIL seq_kv_pulses: got %0d want 3", kv_cnt - k0); end
  endtask

  task automatic test_bad_frames();
    int k0, f0;
    k0 = kv_cnt; f0 = fe_cnt;
    send_frame(8'h1A, 1'b0, 1'b1);
    compared++; if (fe_cnt - f0 != 1) begin mismatched++; $display("FAIL parity_frame_err: got %0d want 1", fe_cnt - f0); end
    compared++; if (kv_cnt - k0 != 0) begin mismatched++; $display("FAIL parity_kv: got %0d want 0", kv_cnt - k0); end
    compared++; if (keycode !== 16'hF01C) begin mismatched++; $display("FAIL parity_keycode: got %h want f01c", keycode); end
    send_frame(8'h1A, 1'b1, 1'b0);
    compared++; if (fe_cnt - f0 != 2) begin mismatched++; $display("FAIL stop_frame_err: got %0d want 2", fe_cnt - f0); end
    compared++; if (kv_cnt - k0 != 0) begin mismatched++; $display("FAIL stop_kv: got %0d want 0", kv_cnt - k0); end
    compared++; if (keycode !== 16'hF01C) begin mismatched++; $display("FAIL stop_keycode: got %h want f01c", keycode); end
  endtask

  task automatic test_timeout();
    int k0, f0;
    k0 = kv_cnt; f0 = fe_cnt;
    ps2_bit(1'b0);
    ps2_bit(1'b1); ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b0);
    compared++; if (rx_busy !== 1'b1) begin mismatched++; $display("FAIL timeout_busy_mid: got %b want 1", rx_busy); end
    repeat (2500) @(negedge clk);
    compared++; if (fe_cnt - f0 != 1) begin mismatched++; $display("FAIL timeout_frame_err: got %0d want 1", fe_cnt - f0); end
    compared++; if (fe_cyc - pin_fall_cyc != int'(2 + FL + TO)) begin mismatched++; $display("FAIL timeout_latency: got %0d want %0d", fe_cyc - pin_fall_cyc, 2 + FL + TO); end
    compared++; if (rx_busy !== 1'b0) begin mismatched++; $display("FAIL timeout_busy_after: got %b want 0", rx_busy); end
    compared++; if (kv_cnt - k0 != 0) begin mismatched++; $display("FAIL timeout_kv: got %0d want 0", kv_cnt - k0); end
    idle_gap();
    send_frame(8'h15, 1'b1, 1'b1);
    compared++; if (keycode[7:0] !== 8'h15) begin mismatched++; $display("FAIL timeout_next_byte: got %h want 15", keycode[7:0]); end
    compared++; if (keycode !== 16'h1C15) begin mismatched++; $display("FAIL timeout_next_keycode: got %h want 1c15", keycode); end
  endtask

  task automatic test_glitch();
    int f0;
    logic busy_seen;
    f0 = fe_cnt; busy_seen = 1'b0;
    @(negedge clk) ps2_data = 1'b0;
    repeat (10) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (2) @(negedge clk);
    ps2_clk = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (rx_busy) busy_seen = 1'b1;
    end
    compared++; if (busy_seen !== 1'b0) begin mismatched++; $display("FAIL glitch_busy: got %b want 0", busy_seen); end
    compared++; if (fe_cnt - f0 != 0) begin mismatched++; $display("FAIL glitch_frame_err: got %0d want 0", fe_cnt - f0); end
    ps2_data = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  task automatic test_reset_midframe();
    int k0, f0;
    k0 = kv_cnt; f0 = fe_cnt;
    ps2_bit(1'b0);
    ps2_bit(1'b0); ps2_bit(1'b0); ps2_bit(1'b1);
    ps2_bit(1'b1); ps2_bit(1'b1); ps2_bit(1'b0);
    @(negedge clk) rst = 1'b0;
    @(negedge clk) rst = 1'b1;
    compared++; if (keycode !== 16'h0000) begin mismatched++; $display("FAIL midrst_keycode: got %h want 0000", keycode); end
    compared++; if (rx_busy !== 1'b0) begin mismatched++; $display("FAIL midrst_busy: got %b want 0", rx_busy); end
    idle_gap();
    compared++; if ((kv_cnt - k0) + (fe_cnt - f0) != 0) begin mismatched++; $display("FAIL midrst_pulses: got %0d want 0", (kv_cnt - k0) + (fe_cnt - f0)); end
    send_frame(8'h1C, 1'b1, 1'b1);
    compared++; if (keycode !== 16'h001C) begin mismatched++; $display("FAIL midrst_next_keycode: got %h want 001c", keycode); end
    compared++; if (kv_cnt - k0 != 1) begin mismatched++; $display("FAIL midrst_next_kv: got %0d want 1", kv_cnt - k0); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_sequence();
    test_bad_frames();
    test_timeout();
    test_glitch();
    test_reset_midframe();
    compared++; if (both_cnt != 0) begin mismatched++; $display("FAIL kv_fe_overlap: got %0d want 0", both_cnt); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
